// File: rtl/oc8051_ifetch.sv
// Instruction fetch stage: reads internal ROM or the external byte bus, sizes
// the opcode, and hands op1..op3/op_pc to the decoder over valid/ready.
module oc8051_ifetch #(
  parameter int unsigned INT_ROM_WID = 7,
  parameter logic [15:0] RESET_PC    = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] rom_addr,
  input  logic        rom_ea_int,
  input  logic [7:0]  rom_data1,
  input  logic [7:0]  rom_data2,
  input  logic [7:0]  rom_data3,
  output logic [15:0] ext_addr,
  output logic        ext_stb,
  input  logic        ext_ack,
  input  logic [7:0]  ext_data,
  input  logic        pc_load,
  input  logic [15:0] pc_in,
  output logic [7:0]  op1,
  output logic [7:0]  op2,
  output logic [7:0]  op3,
  output logic [15:0] op_pc,
  output logic        op_valid,
  input  logic        op_ready
);

  typedef enum logic [2:0] {S_ISSUE, S_WAIT, S_XREQ, S_HOLD, S_DRAIN} state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] rom_addr_q, rom_addr_d;
  logic [15:0] ext_addr_q, ext_addr_d;
  logic        ext_stb_q, ext_stb_d;
  logic [7:0]  op1_q, op1_d, op2_q, op2_d, op3_q, op3_d;
  logic [15:0] op_pc_q, op_pc_d;
  logic        op_valid_q, op_valid_d;
  logic        int_hit_q, int_hit_d;
  logic [1:0]  k_q, k_d;
  logic [1:0]  len_q, len_d;

  logic [1:0]  rom_len, ext_len, x_len;
  logic [15:0] last_addr;
  logic        in_rom;

  // MCS-51 instruction length from the opcode byte
  function automatic logic [1:0] op_len(input logic [7:0] op);
    logic [1:0] l;
    l = 2'd1;
    if (op[3:0] == 4'h1) l = 2'd2;
    case (op) inside
      8'h02, 8'h10, 8'h12, 8'h20, 8'h30, 8'h43, 8'h53, 8'h63, 8'h75, 8'h85,
      8'h90, 8'hD5, [8'hB4:8'hBF]: l = 2'd3;
      8'h05, 8'h15, 8'h24, 8'h25, 8'h34, 8'h35, 8'h40, 8'h42, 8'h44, 8'h45,
      8'h50, 8'h52, 8'h54, 8'h55, 8'h60, 8'h62, 8'h64, 8'h65, 8'h70, 8'h72,
      8'h74, 8'h76, 8'h77, [8'h78:8'h7F], 8'h80, 8'h82, 8'h86, 8'h87,
      [8'h88:8'h8F], 8'h92, 8'h94, 8'h95, 8'hA0, 8'hA2, 8'hA6, 8'hA7,
      [8'hA8:8'hAF], 8'hB0, 8'hB2, 8'hC0, 8'hC2, 8'hC5, 8'hD0, 8'hD2,
      [8'hD8:8'hDF], 8'hE5, 8'hF5: l = 2'd2;
      default: ;
    endcase
    return l;
  endfunction

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    rom_addr_d = rom_addr_q;
    ext_addr_d = ext_addr_q;
    ext_stb_d  = ext_stb_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    op3_d      = op3_q;
    op_pc_d    = op_pc_q;
    op_valid_d = op_valid_q;
    int_hit_d  = int_hit_q;
    k_d        = k_q;
    len_d      = len_q;

    rom_len   = op_len(rom_data1);
    ext_len   = op_len(ext_data);
    x_len     = (k_q == 2'd0) ? ext_len : len_q;
    last_addr = pc_q + 16'(rom_len) - 16'd1;
    in_rom    = (last_addr >> INT_ROM_WID) == 16'd0;

    case (state_q)
      S_ISSUE: begin
        int_hit_d = rom_ea_int;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (int_hit_q && in_rom) begin
          op1_d      = rom_data1;
          op2_d      = (rom_len >= 2'd2) ? rom_data2 : 8'h00;
          op3_d      = (rom_len == 2'd3) ? rom_data3 : 8'h00;
          op_pc_d    = pc_q;
          len_d      = rom_len;
          op_valid_d = 1'b1;
          state_d    = S_HOLD;
        end else begin
          // Bytes are cleared up front so unused slots read as 00
          op1_d      = 8'h00;
          op2_d      = 8'h00;
          op3_d      = 8'h00;
          k_d        = 2'd0;
          ext_addr_d = pc_q;
          ext_stb_d  = 1'b1;
          state_d    = S_XREQ;
        end
      end
      S_XREQ: begin
        if (ext_ack) begin
          len_d = x_len;
          case (k_q)
            2'd0:    op1_d = ext_data;
            2'd1:    op2_d = ext_data;
            default: op3_d = ext_data;
          endcase
          if ((3'({1'b0, k_q}) + 3'd1) < 3'({1'b0, x_len})) begin
            k_d        = k_q + 2'd1;
            ext_addr_d = pc_q + 16'(k_q) + 16'd1;
          end else begin
            ext_stb_d  = 1'b0;
            op_pc_d    = pc_q;
            op_valid_d = 1'b1;
            state_d    = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (op_ready) begin
          op_valid_d = 1'b0;
          pc_d       = pc_q + 16'(len_q);
          rom_addr_d = pc_q + 16'(len_q);
          state_d    = S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (ext_ack) begin
          ext_stb_d = 1'b0;
          state_d   = S_ISSUE;
        end
      end
      default: state_d = S_ISSUE;
    endcase

    // Redirect overrides everything; an unacked external cycle must finish first
    if (pc_load) begin
      pc_d       = pc_in;
      rom_addr_d = pc_in;
      op_valid_d = 1'b0;
      if ((state_q == S_XREQ || state_q == S_DRAIN) && !ext_ack) begin
        state_d    = S_DRAIN;
        ext_stb_d  = ext_stb_q;
        ext_addr_d = ext_addr_q;
      end else begin
        ext_stb_d = 1'b0;
        state_d   = S_ISSUE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_ISSUE;
      pc_q       <= RESET_PC;
      rom_addr_q <= RESET_PC;
      ext_addr_q <= 16'h0000;
      ext_stb_q  <= 1'b0;
      op1_q      <= 8'h00;
      op2_q      <= 8'h00;
      op3_q      <= 8'h00;
      op_pc_q    <= 16'h0000;
      op_valid_q <= 1'b0;
      int_hit_q  <= 1'b0;
      k_q        <= 2'd0;
      len_q      <= 2'd1;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      rom_addr_q <= rom_addr_d;
      ext_addr_q <= ext_addr_d;
      ext_stb_q  <= ext_stb_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      op3_q      <= op3_d;
      op_pc_q    <= op_pc_d;
      op_valid_q <= op_valid_d;
      int_hit_q  <= int_hit_d;
      k_q        <= k_d;
      len_q      <= len_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign ext_addr = ext_addr_q;
  assign ext_stb  = ext_stb_q;
  assign op1      = op1_q;
  assign op2      = op2_q;
  assign op3      = op3_q;
  assign op_pc    = op_pc_q;
  assign op_valid = op_valid_q;

endmodule

// File: tb/tb_oc8051_ifetch.sv
// Bench for oc8051_ifetch: ROM and external-bus models plus an instruction-level
// reference that predicts each handed-off instruction from the memory images.
module tb_oc8051_ifetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] rom_addr;
  logic        rom_ea_int;
  logic [7:0]  rom_data1, rom_data2, rom_data3;
  logic [15:0] ext_addr;
  logic        ext_stb;
  logic        ext_ack = 1'b0;
  logic [7:0]  ext_data = 8'h00;
  logic        pc_load;
  logic [15:0] pc_in;
  logic [7:0]  op1, op2, op3;
  logic [15:0] op_pc;
  logic        op_valid;
  logic        op_ready;

  logic [7:0]  rom_mem [65536];
  logic [7:0]  ext_mem [65536];
  int          len_tab [256];
  int          ext_lat;
  int          wait_cnt = 0;
  int          stb_cycles = 0;
  logic [15:0] ack_log [$];
  int          checks = 0;
  int          failures = 0;

  oc8051_ifetch #(.INT_ROM_WID(7), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_ea_int(rom_ea_int),
    .rom_data1(rom_data1), .rom_data2(rom_data2), .rom_data3(rom_data3),
    .ext_addr(ext_addr), .ext_stb(ext_stb), .ext_ack(ext_ack), .ext_data(ext_data),
    .pc_load(pc_load), .pc_in(pc_in), .op1(op1), .op2(op2), .op3(op3),
    .op_pc(op_pc), .op_valid(op_valid), .op_ready(op_ready)
  );

  always #5 clk = ~clk;

  // Internal ROM: registered read, hit flag for the low 128 bytes
  assign rom_ea_int = (rom_addr < 16'd128);
  always @(posedge clk) begin
    rom_data1 <= rom_mem[rom_addr];
    rom_data2 <= rom_mem[rom_addr + 16'd1];
    rom_data3 <= rom_mem[rom_addr + 16'd2];
  end

  // External program memory: acks after ext_lat strobed cycles
  always @(negedge clk) begin
    if (ext_ack) begin
      ext_ack  = 1'b0;
      wait_cnt = ext_lat;
    end else if (ext_stb && !rst) begin
      if (wait_cnt == 0) begin
        ext_ack  = 1'b1;
        ext_data = ext_mem[ext_addr];
        ack_log.push_back(ext_addr);
      end else begin
        wait_cnt = wait_cnt - 1;
      end
    end else begin
      wait_cnt = ext_lat;
    end
  end

  always @(posedge clk) if (ext_stb === 1'b1) stb_cycles <= stb_cycles + 1;

  initial begin
    #1ms;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic build_len_tab();
    byte unsigned three[$] = {8'h02, 8'h10, 8'h12, 8'h20, 8'h30, 8'h43, 8'h53,
                              8'h63, 8'h75, 8'h85, 8'h90, 8'hD5};
    byte unsigned two[$]   = {8'h05, 8'h15, 8'h24, 8'h25, 8'h34, 8'h35, 8'h40,
                              8'h42, 8'h44, 8'h45, 8'h50, 8'h52, 8'h54, 8'h55,
                              8'h60, 8'h62, 8'h64, 8'h65, 8'h70, 8'h72, 8'h74,
                              8'h76, 8'h77, 8'h80, 8'h82, 8'h86, 8'h87, 8'h92,
                              8'h94, 8'h95, 8'hA0, 8'hA2, 8'hA6, 8'hA7, 8'hB0,
                              8'hB2, 8'hC0, 8'hC2, 8'hC5, 8'hD0, 8'hD2, 8'hE5,
                              8'hF5};
    for (int i = 0; i < 256; i++) len_tab[i] = (i % 16 == 1) ? 2 : 1;
    foreach (two[i]) len_tab[two[i]] = 2;
    for (int i = 8'h78; i <= 8'h7F; i++) len_tab[i] = 2;
    for (int i = 8'h88; i <= 8'h8F; i++) len_tab[i] = 2;
    for (int i = 8'hA8; i <= 8'hAF; i++) len_tab[i] = 2;
    for (int i = 8'hD8; i <= 8'hDF; i++) len_tab[i] = 2;
    foreach (three[i]) len_tab[three[i]] = 3;
    for (int i = 8'hB4; i <= 8'hBF; i++) len_tab[i] = 3;
  endtask

  // Instruction at pc: internal only if it starts and ends below 0x80
  task automatic model(input logic [15:0] pc, output logic [7:0] b1, output logic [7:0] b2,
                       output logic [7:0] b3, output int len, output bit internal);
    logic [7:0] b [3];
    logic [15:0] last;
    len  = len_tab[rom_mem[pc]];
    last = pc + 16'(len - 1);
    internal = (pc < 16'd128) && (last < 16'd128);
    if (!internal) len = len_tab[ext_mem[pc]];
    for (int i = 0; i < 3; i++) begin
      if (i >= len) b[i] = 8'h00;
      else if (internal) b[i] = rom_mem[pc + 16'(i)];
      else b[i] = ext_mem[pc + 16'(i)];
    end
    b1 = b[0]; b2 = b[1]; b3 = b[2];
  endtask

  // Wait for one instruction, check it, stall, accept (optionally with redirect)
  task automatic take(input logic [15:0] pc, input int stall, input bit redir,
                      input logic [15:0] tgt, output logic [15:0] npc);
    logic [7:0] e1, e2, e3;
    int len, n;
    bit internal;
    logic [15:0] ra;
    model(pc, e1, e2, e3, len, internal);
    n = 0;
    while (!op_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("op_valid_rise", 64'(op_valid), 64'd1);
    if (internal) chk("issue_to_valid", 64'(n), 64'd2);
    chk("op_bytes", 64'({op1, op2, op3}), 64'({e1, e2, e3}));
    chk("op_pc", 64'(op_pc), 64'(pc));
    ra = rom_addr;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(op_valid), 64'd1);
      chk("hold_payload", 64'({op1, op2, op3, op_pc}), 64'({e1, e2, e3, pc}));
      chk("hold_rom_addr", 64'(rom_addr), 64'(ra));
    end
    op_ready = 1'b1;
    if (redir) begin
      pc_load = 1'b1;
      pc_in   = tgt;
    end
    @(negedge clk);
    op_ready = 1'b0;
    pc_load  = 1'b0;
    npc = redir ? tgt : pc + 16'(len);
    chk("next_rom_addr", 64'(rom_addr), 64'(npc));
    chk("valid_drop", 64'(op_valid), 64'd0);
  endtask

  initial begin
    logic [15:0] pc, tgt;
    int n, s0, a0;
    bit vbad, redir;

    rst = 1'b1; pc_load = 1'b0; pc_in = 16'h0000; op_ready = 1'b0; ext_lat = 2;
    build_len_tab();
    for (int i = 0; i < 65536; i++) begin
      rom_mem[i] = 8'h00;
      ext_mem[i] = 8'h00;
    end
    {rom_mem[0], rom_mem[1], rom_mem[2]} = {8'h02, 8'h00, 8'h35};
    {rom_mem[16'h35], rom_mem[16'h36], rom_mem[16'h37], rom_mem[16'h38]} = {8'h74, 8'h55, 8'hE4, 8'hF6};
    {rom_mem[16'h39], rom_mem[16'h3A], rom_mem[16'h3B]} = {8'h75, 8'h80, 8'h12};
    rom_mem[16'h7E] = 8'h90;
    {ext_mem[16'h7E], ext_mem[16'h7F], ext_mem[16'h80]} = {8'h90, 8'h12, 8'h34};
    ext_mem[16'h0100] = 8'h02;

    @(negedge clk);
    @(negedge clk);
    chk("reset_rom_addr", 64'(rom_addr), 64'h0000);
    chk("reset_ext", 64'({ext_stb, ext_addr}), 64'h0);
    chk("reset_ops", 64'({op_valid, op1, op2, op3, op_pc}), 64'h0);

    rst = 1'b0;
    take(16'h0000, 0, 1'b0, 16'h0, pc);
    take(pc, 0, 1'b1, 16'h0037, pc);

    s0 = stb_cycles;
    take(pc, 0, 1'b0, 16'h0, pc);
    chk("rom_only_no_stb", 64'(stb_cycles - s0), 64'd0);
    take(pc, 0, 1'b0, 16'h0, pc);
    take(pc, 5, 1'b0, 16'h0, pc);
    take(pc, 0, 1'b1, 16'h007E, pc);

    a0 = ack_log.size();
    ext_lat = 2;
    take(pc, 1, 1'b0, 16'h0, pc);
    chk("ext_ack_count", 64'(ack_log.size() - a0), 64'd3);
    if (ack_log.size() == a0 + 3)
      chk("ext_addr_seq", 64'({ack_log[a0], ack_log[a0+1], ack_log[a0+2]}), 64'h007E_007F_0080);
    chk("pc_after_straddle", 64'(pc), 64'h0081);
    take(pc, 0, 1'b1, 16'h0100, pc);

    // Redirect while an external fetch is pending
    ext_lat = 6;
    n = 0;
    while (!ext_stb && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("xreq_stb", 64'({ext_stb, ext_addr}), 64'h1_0100);
    a0 = ack_log.size();
    pc_load = 1'b1; pc_in = 16'h0035;
    @(negedge clk);
    pc_load = 1'b0;
    chk("drain_stb_held", 64'({ext_stb, ext_addr, op_valid}), 64'({1'b1, 16'h0100, 1'b0}));
    vbad = 1'b0; n = 0;
    while (ext_stb && n < 50) begin
      @(negedge clk);
      if (op_valid) vbad = 1'b1;
      n++;
    end
    chk("drain_no_valid", 64'(vbad), 64'd0);
    chk("drain_one_ack", 64'(ack_log.size() - a0), 64'd1);
    chk("drain_target", 64'(rom_addr), 64'h0035);
    take(16'h0035, 0, 1'b1, 16'h0040, pc);
    take(pc, 1, 1'b1, 16'hFFFF, pc);

    ext_lat = 1;
    take(pc, 0, 1'b0, 16'h0, pc);
    chk("wrap_pc", 64'(pc), 64'h0000);

    // Asynchronous reset in the middle of an external fetch
    pc_load = 1'b1; pc_in = 16'h0100; ext_lat = 20;
    @(negedge clk);
    pc_load = 1'b0;
    n = 0;
    while (!ext_stb && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("pre_reset_stb", 64'(ext_stb), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_stb", 64'({ext_stb, op_valid}), 64'd0);
    chk("async_reset_addr", 64'(rom_addr), 64'h0000);

    // Randomized images and traffic against the instruction-level model
    for (int i = 0; i < 65536; i++) begin
      rom_mem[i] = 8'($urandom);
      ext_mem[i] = 8'($urandom);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    pc = 16'h0000;
    for (int it = 0; it < 40; it++) begin
      ext_lat = $urandom_range(0, 3);
      redir = ($urandom_range(0, 5) == 0) || (it == 20);
      tgt = (it == 20) ? 16'hFFF0 + 16'($urandom_range(0, 12)) : 16'($urandom_range(0, 160));
      take(pc, $urandom_range(0, 2), redir, tgt, pc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/oc8051_ifetch.md
Name: oc8051_ifetch

Overview:
Instruction fetch stage sitting directly downstream of oc8051_rom and upstream of the decoder. It drives the program-ROM address, captures the three registered ROM bytes, and determines MCS-51 instruction length from the opcode. Instructions not fully inside internal ROM are fetched byte-by-byte over an external program-memory strobe/ack bus. The assembled instruction (op1..op3, op_pc) is handed to the decoder with a valid/ready handshake.

Parameters:
INT_ROM_WID, 7, internal ROM spans addresses below 2^INT_ROM_WID; must match the ROM instance
RESET_PC, 16'h0000, fetch address after reset

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
rom_addr  out  16  address to oc8051_rom (registered)
rom_ea_int  in  1  ROM internal-hit flag, combinational from rom_addr
rom_data1  in  8  byte at rom_addr, valid one cycle after address is sampled
rom_data2  in  8  byte at rom_addr+1
rom_data3  in  8  byte at rom_addr+2
ext_addr  out  16  external program-memory byte address
ext_stb  out  1  external request, held until ext_ack
ext_ack  in  1  external byte valid on ext_data this cycle
ext_data  in  8  external byte
pc_load  in  1  redirect request from decoder (jump/call/ret/irq)
pc_in  in  16  redirect target
op1  out  8  opcode
op2  out  8  second byte, 00 if length < 2
op3  out  8  third byte, 00 if length < 3
op_pc  out  16  address of op1
op_valid  out  1  instruction available
op_ready  in  1  decoder accepts when op_valid & op_ready at rising edge

Behaviour:
- Reset (async): pc=RESET_PC, rom_addr=RESET_PC, ext_addr=0, ext_stb=0, op1..op3=00, op_pc=0, op_valid=0, state=ISSUE.
- Length table (combinational on opcode). All arithmetic is 16-bit modulo, so FFFF+1=0000.
  - 3 bytes: 02,10,12,20,30,43,53,63,75,85,90,B4–BF,D5.
  - 2 bytes: every x1; 05,15,24,25,34,35,40,42,44,45,50,52,54,55,60,62,64,65,70,72,74,76,77,78–7F,80,82,86,87,88–8F,92,94,95,A0,A2,A6,A7,A8–AF,B0,B2,C0,C2,C5,D0,D2,D8–DF,E5,F5.
  - All others: 1 byte (A5 included).
- ISSUE: rom_addr=pc is stable. Register rom_ea_int as int_hit. Next state: WAIT.
- WAIT: ROM bytes are valid. len=LEN(rom_data1).
  - If int_hit and (pc+len-1) < 2^INT_ROM_WID: load op1..op3 from ROM with unused bytes forced to 00, op_pc=pc, op_valid=1, go to HOLD.
  - Otherwise: go to XREQ with k=0, ext_addr=pc, ext_stb=1.
- XREQ: ext_stb stays high with stable ext_addr until ext_ack is sampled.
  - On ack, store ext_data into byte k. When k=0, len=LEN(ext_data).
  - If k+1<len: k++, ext_addr=pc+k. The request is back-to-back; ext_stb stays high.
  - Else: ext_stb=0, zero unused bytes, op_valid=1, go to HOLD.
- HOLD: op1..op3, op_pc and op_valid are held stable while op_ready=0.
  - On accept: op_valid=0, pc=pc+len, rom_addr=pc+len, go to ISSUE.
  - Internal throughput is 1 instruction per 3 cycles. Issue-to-valid latency is 2 cycles.
- pc_load has priority in every state.
  - pc=pc_in, rom_addr=pc_in, op_valid=0 on the same edge, go to ISSUE.
  - If HOLD is accepted on the same edge, the redirect wins and no increment occurs.
  - In XREQ with ext_stb high and no ack, go to DRAIN: keep ext_stb/ext_addr until ack, discard data, then go to ISSUE at the latched target. A second pc_load during DRAIN updates the target.
  - If ext_ack and pc_load coincide, the byte is discarded and the next state is ISSUE.
- rom_ea_int is sampled only in ISSUE. ROM data outside WAIT is ignored.
- Reset mid-operation: everything returns to reset values immediately. An external cycle is abandoned: ext_stb drops asynchronously.

Test Plan:
- ROM 0000: 02 00 35, op_ready=1, release reset → op_valid rises 2 cycles after release; op1=02, op2=00, op3=35, op_pc=0000; next rom_addr=0003.
- ROM 0037: E4 F6 → op1=E4, op2=00, op3=00, op_pc=0037; after accept rom_addr=0038; no ext_stb ever.
- Stall: op_ready=0 for 5 cycles in HOLD → op1..op3/op_pc/op_valid unchanged, rom_addr unchanged; accept on 6th cycle → pc advances by len exactly once.
- INT_ROM_WID=7, pc=007E, opcode 90 with ext bytes 90 12 34 and ext_ack 2 cycles late each → ext_addr sequence 007E, 007F, 0080; op1..op3=90 12 34; op_pc=007E; next pc 0081.
- In XREQ at 0100, pc_load with pc_in=0035 before ack → ext_stb held until ack, data discarded, then rom_addr=0035; op_valid stays 0 until the 0035 instruction is ready.
- External 1-byte 00 at FFFF, accept → pc and rom_addr wrap to 0000; async rst asserted mid-XREQ → ext_stb=0 and op_valid=0 without a clock edge.
